// File: rtl/xnor_chk_pkg.sv
// Shared definitions for the XNOR frame checker.
//   lock_state_e : lock FSM states
//   cnt_w()      : width needed to hold a mismatch count of 0..frame_len
package xnor_chk_pkg;

  typedef enum logic [1:0] {HUNT, CONFIRM, LOCKED, FLYWHEEL} lock_state_e;

  function automatic int cnt_w(input int frame_len);
    return $clog2(frame_len + 1);
  endfunction

endpackage

// File: rtl/xnor_bit_acc.sv
// Per-bit XNOR compare, bit index counter and mismatch accumulator.
// Ports:
//   clk, rst           : clock, asynchronous active-high reset
//   in_valid           : in_a/in_b carry a bit this cycle
//   in_a, in_b         : stream bits
//   frame_end          : current valid bit is the last bit of a frame (comb.)
//   frame_mism         : mismatches in the frame including the current bit (comb.)
//   frame_good         : frame_mism is zero (comb.)
module xnor_bit_acc
  import xnor_chk_pkg::*;
#(
  parameter int FRAME_LEN = 8,
  parameter int CNT_W     = cnt_w(FRAME_LEN)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_a,
  input  logic             in_b,
  output logic             frame_end,
  output logic [CNT_W-1:0] frame_mism,
  output logic             frame_good
);

  localparam int IDX_W = $clog2(FRAME_LEN);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  logic [IDX_W-1:0] bit_idx_reg;
  logic [CNT_W-1:0] acc_reg;
  logic             bit_match;

  assign bit_match  = ~(in_a ^ in_b);
  assign frame_end  = in_valid && (bit_idx_reg == LAST_IDX);
  // Running total including the bit on the inputs now; also the next acc value.
  // acc never exceeds FRAME_LEN, so CNT_W bits cannot overflow.
  assign frame_mism = acc_reg + CNT_W'(~bit_match);
  assign frame_good = (frame_mism == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_idx_reg <= '0;
      acc_reg     <= '0;
    end else if (in_valid) begin
      if (frame_end) begin
        // Next valid bit starts a new frame with no gap.
        bit_idx_reg <= '0;
        acc_reg     <= '0;
      end else begin
        bit_idx_reg <= bit_idx_reg + 1'b1;
        acc_reg     <= frame_mism;
      end
    end
  end

endmodule

// File: rtl/xnor_frame_checker.sv
// Frame-based comparator of two serial streams with a lock FSM.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   in_valid     : in_a/in_b carry a bit this cycle
//   in_a, in_b   : stream bits
//   frame_done   : one-cycle pulse after the last bit of a frame
//   frame_match  : last completed frame had zero mismatches
//   mism_count   : mismatch count of last completed frame
//   locked       : streams declared aligned (LOCKED or FLYWHEEL)
module xnor_frame_checker
  import xnor_chk_pkg::*;
#(
  parameter int FRAME_LEN   = 8,
  parameter int LOCK_THRESH = 3,
  parameter int CNT_W       = cnt_w(FRAME_LEN)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_a,
  input  logic             in_b,
  output logic             frame_done,
  output logic             frame_match,
  output logic [CNT_W-1:0] mism_count,
  output logic             locked
);

  localparam int GC_W = $clog2(LOCK_THRESH + 1);

  logic             frame_end;
  logic [CNT_W-1:0] frame_mism;
  logic             frame_good;

  lock_state_e      state_reg, state_next;
  logic [GC_W-1:0]  good_cnt_reg, good_cnt_next;

  xnor_bit_acc #(
    .FRAME_LEN (FRAME_LEN),
    .CNT_W     (CNT_W)
  ) u_bit_acc (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_a       (in_a),
    .in_b       (in_b),
    .frame_end  (frame_end),
    .frame_mism (frame_mism),
    .frame_good (frame_good)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= HUNT;
      good_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      good_cnt_reg <= good_cnt_next;
    end
  end

  // The FSM only moves on a frame end; otherwise everything holds.
  always_comb begin
    state_next    = state_reg;
    good_cnt_next = good_cnt_reg;
    if (frame_end) begin
      unique case (state_reg)
        HUNT: begin
          if (frame_good) begin
            good_cnt_next = GC_W'(1);
            state_next    = (LOCK_THRESH == 1) ? LOCKED : CONFIRM;
          end
        end
        CONFIRM: begin
          if (frame_good) begin
            good_cnt_next = good_cnt_reg + 1'b1;
            if (int'(good_cnt_reg) + 1 == LOCK_THRESH) begin
              state_next = LOCKED;
            end
          end else begin
            good_cnt_next = '0;
            state_next    = HUNT;
          end
        end
        LOCKED: begin
          if (!frame_good) begin
            state_next = FLYWHEEL;
          end
        end
        FLYWHEEL: begin
          if (frame_good) begin
            state_next = LOCKED;
          end else begin
            good_cnt_next = '0;
            state_next    = HUNT;
          end
        end
        default: begin
          good_cnt_next = '0;
          state_next    = HUNT;
        end
      endcase
    end
  end

  // Registered outputs; locked tracks the state being entered so it changes
  // together with the frame_done pulse of the frame that caused it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_done  <= 1'b0;
      frame_match <= 1'b0;
      mism_count  <= '0;
      locked      <= 1'b0;
    end else begin
      frame_done <= frame_end;
      locked     <= (state_next == LOCKED) || (state_next == FLYWHEEL);
      if (frame_end) begin
        frame_match <= frame_good;
        mism_count  <= frame_mism;
      end
    end
  end

endmodule

// File: tb/tb_xnor_frame_checker.sv
module tb_xnor_frame_checker;

  localparam int FRAME_LEN   = 8;
  localparam int LOCK_THRESH = 3;
  localparam int CNT_W       = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_a = 1'b0;
  logic             in_b = 1'b0;
  logic             frame_done;
  logic             frame_match;
  logic [CNT_W-1:0] mism_count;
  logic             locked;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: list of per-bit mismatch flags of the open frame,
  // plus run lengths of consecutive good / bad frames.
  int q_mism[$];
  bit m_locked;
  int run_good;
  int run_bad;
  int frame_no;
  bit exp_done;
  bit exp_match;
  int exp_cnt;

  xnor_frame_checker #(
    .FRAME_LEN   (FRAME_LEN),
    .LOCK_THRESH (LOCK_THRESH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_a        (in_a),
    .in_b        (in_b),
    .frame_done  (frame_done),
    .frame_match (frame_match),
    .mism_count  (mism_count),
    .locked      (locked)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic compare_outputs(input string where);
    check_val({where, ".frame_done"}, 32'(frame_done), 32'(exp_done));
    check_val({where, ".frame_match"}, 32'(frame_match), 32'(exp_match));
    check_val({where, ".mism_count"}, 32'(mism_count), 32'(exp_cnt));
    check_val({where, ".locked"}, 32'(locked), 32'(m_locked));
  endtask

  task automatic model_reset();
    q_mism.delete();
    m_locked  = 1'b0;
    run_good  = 0;
    run_bad   = 0;
    exp_done  = 1'b0;
    exp_match = 1'b0;
    exp_cnt   = 0;
  endtask

  // Lock rule: need LOCK_THRESH good frames in a row to lock; once locked,
  // only two bad frames in a row drop the lock.
  task automatic model_update(input logic v, input logic a, input logic b);
    int sum;
    exp_done = 1'b0;
    if (v) begin
      q_mism.push_back((a != b) ? 1 : 0);
      if (q_mism.size() == FRAME_LEN) begin
        sum = 0;
        foreach (q_mism[k]) sum += q_mism[k];
        q_mism.delete();
        exp_done  = 1'b1;
        exp_cnt   = sum;
        exp_match = (sum == 0);
        if (!m_locked) begin
          if (sum == 0) begin
            run_good++;
            if (run_good >= LOCK_THRESH) begin
              m_locked = 1'b1;
              run_bad  = 0;
            end
          end else begin
            run_good = 0;
          end
        end else begin
          if (sum == 0) begin
            run_bad = 0;
          end else begin
            run_bad++;
            if (run_bad == 2) begin
              m_locked = 1'b0;
              run_good = 0;
              run_bad  = 0;
            end
          end
        end
        frame_no++;
        $display("frame %0d: mism=%0d match=%0d locked=%0d (exp mism=%0d locked=%0d)",
                 frame_no, mism_count, frame_match, locked, exp_cnt, m_locked);
      end
    end
  endtask

  task automatic step(input string where, input logic v, input logic a, input logic b);
    @(negedge clk);
    in_valid = v;
    in_a     = a;
    in_b     = b;
    @(posedge clk);
    #1;
    model_update(v, a, b);
    compare_outputs(where);
  endtask

  // Asynchronous reset: outputs must clear before any clock edge.
  task automatic apply_reset(input string where);
    @(negedge clk);
    in_valid = 1'b0;
    rst      = 1'b1;
    #1;
    model_reset();
    compare_outputs({where, ".async"});
    @(negedge clk);
    rst = 1'b0;
    compare_outputs({where, ".held"});
  endtask

  // Frame with exactly nbad mismatches at random positions.
  task automatic send_frame(input string where, input int nbad);
    bit bad_pos[FRAME_LEN];
    int placed;
    logic a;
    foreach (bad_pos[k]) bad_pos[k] = 1'b0;
    placed = 0;
    while (placed < nbad) begin
      int p;
      p = $urandom_range(FRAME_LEN - 1);
      if (!bad_pos[p]) begin
        bad_pos[p] = 1'b1;
        placed++;
      end
    end
    for (int i = 0; i < FRAME_LEN; i++) begin
      a = 1'($urandom);
      step(where, 1'b1, a, a ^ bad_pos[i]);
    end
  endtask

  initial begin
    logic [7:0] pat_a;
    logic [7:0] pat_b;
    frame_no = 0;
    model_reset();

    apply_reset("rst0");
    for (int i = 0; i < 6; i++) step("idle", 1'b0, 1'($urandom), 1'($urandom));

    // Mismatch count: 4 mismatches, stays unlocked.
    pat_a = 8'b1010_1010;
    pat_b = 8'b1010_0101;
    for (int i = 7; i >= 0; i--) step("mism4", 1'b1, pat_a[i], pat_b[i]);

    // Clean lock: three clean frames back to back.
    for (int f = 0; f < 3; f++) send_frame("lock", 0);

    // Flywheel behaviour.
    send_frame("fly_bad1", 1);
    send_frame("fly_good", 0);
    send_frame("fly_bad2", 1 + $urandom_range(6));
    send_frame("fly_bad3", 1 + $urandom_range(6));

    // Stalls interleaved with one frame's worth of valid bits.
    for (int i = 0; i < FRAME_LEN; i++) begin
      int gaps;
      logic a;
      gaps = $urandom_range(3);
      for (int g = 0; g < gaps; g++) step("stall_gap", 1'b0, 1'($urandom), 1'($urandom));
      a = 1'($urandom);
      step("stall_bit", 1'b1, a, (i == 3) ? ~a : a);
    end
    for (int g = 0; g < 3; g++) step("stall_tail", 1'b0, 1'($urandom), 1'($urandom));

    // Reset mid-frame, then a full aligned frame.
    for (int i = 0; i < 5; i++) step("pre_rst", 1'b1, 1'b1, 1'($urandom));
    apply_reset("rst_mid");
    send_frame("post_rst", 0);
    step("post_rst_idle", 1'b0, 1'b0, 1'b0);

    // Randomized run: sparse mismatches so lock is gained and lost.
    for (int i = 0; i < 800; i++) begin
      logic v;
      logic a;
      v = ($urandom_range(3) != 0);
      a = 1'($urandom);
      step("rand", v, a, a ^ ($urandom_range(29) == 0));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
